// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - multi-channel step sequencer with rate divider, gates and live recording
// Optional feature: define STEP_SEQ_SWING_EN to add the swing input (even steps longer, odd steps shorter).
module step_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int STEPS       = 16,
  parameter int PERIOD_W    = 32,
  parameter int GATE_CYCLES = 2_500_000,
  localparam int POS_W      = $clog2(STEPS)
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                run,
  input  logic                rewind,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic [POS_W:0]      pattern_len,
  input  logic [CHANNELS-1:0] rec_set,
  input  logic [CHANNELS-1:0] rec_clr,
  input  logic                clear_all,
`ifdef STEP_SEQ_SWING_EN
  input  logic [PERIOD_W-2:0] swing,
`endif
  output logic [POS_W-1:0]    pos,
  output logic                step_strobe,
  output logic [CHANNELS-1:0] gate,
  output logic [CHANNELS-1:0] cur_bits
);

  localparam int CW = PERIOD_W + 1;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  logic [STEPS-1:0]    pat  [CHANNELS];
  logic [GW-1:0]       gcnt [CHANNELS];
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       dur;
  logic [PERIOD_W-1:0] per;
  logic [POS_W:0]      len;
  logic [POS_W-1:0]    wrap_pos;
  logic [POS_W-1:0]    nxt_pos;
  logic                adv;
  logic                entry;
`ifdef STEP_SEQ_SWING_EN
  logic [PERIOD_W-1:0] swing_eff;
`endif

  always_comb begin
    per = (step_period == '0) ? PERIOD_W'(1) : step_period;
    len = (pattern_len == '0 || pattern_len > (POS_W+1)'(STEPS)) ? (POS_W+1)'(STEPS) : pattern_len;
`ifdef STEP_SEQ_SWING_EN
    // Swing is clamped so an odd step never shrinks below one cycle.
    swing_eff = ({1'b0, swing} >= per - PERIOD_W'(1)) ? per - PERIOD_W'(1) : {1'b0, swing};
    dur = pos[0] ? ({1'b0, per} - {1'b0, swing_eff}) : ({1'b0, per} + {1'b0, swing_eff});
`else
    dur = {1'b0, per};
`endif
    adv      = run && (cnt >= dur - CW'(1));
    // >= also pulls pos back into range after pattern_len shrinks.
    wrap_pos = ({1'b0, pos} >= len - (POS_W+1)'(1)) ? '0 : pos + POS_W'(1);
    entry    = rewind ? run : adv;
    nxt_pos  = rewind ? '0 : (adv ? wrap_pos : pos);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      pos         <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= entry;
      pos         <= nxt_pos;
      if (rewind || adv) cnt <= '0;
      else if (run)      cnt <= cnt + CW'(1);
    end
  end

  // Recording always targets the pre-advance position.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) pat[c] <= '0;
    end else if (clear_all) begin
      for (int c = 0; c < CHANNELS; c++) pat[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        pat[c][pos] <= (pat[c][pos] | rec_set[c]) & ~rec_clr[c];
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      gate <= '0;
      for (int c = 0; c < CHANNELS; c++) gcnt[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (entry && pat[c][nxt_pos]) begin
          gate[c] <= 1'b1;
          gcnt[c] <= GW'(GATE_CYCLES - 1);
        end else if (gate[c]) begin
          if (gcnt[c] == '0) gate[c] <= 1'b0;
          else               gcnt[c] <= gcnt[c] - GW'(1);
        end
      end
    end
  end

  always_comb begin
    cur_bits = '0;
    for (int c = 0; c < CHANNELS; c++) cur_bits[c] = pat[c][pos];
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer against a behavioural model
module tb_step_sequencer;
  localparam int CH = 4;
  localparam int ST = 16;
  localparam int PW = 32;
  localparam int G  = 10;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          rewind = 1'b0;
  logic          clear_all = 1'b0;
  logic [PW-1:0] step_period = 32'd4;
  logic [4:0]    pattern_len = 5'd0;
  logic [CH-1:0] rec_set = '0;
  logic [CH-1:0] rec_clr = '0;
`ifdef STEP_SEQ_SWING_EN
  logic [PW-2:0] swing = '0;
`endif
  logic [3:0]    pos;
  logic          step_strobe;
  logic [CH-1:0] gate;
  logic [CH-1:0] cur_bits;

  int n_cmp = 0;
  int n_fail = 0;

  bit     m_pat [CH][ST];
  int     m_pos, m_el;
  bit     m_strobe;
  longint m_cyc = 0;
  longint g_until [CH];

  step_sequencer #(.CHANNELS(CH), .STEPS(ST), .PERIOD_W(PW), .GATE_CYCLES(G)) dut (
    .sys_clk(sys_clk), .reset(reset), .run(run), .rewind(rewind),
    .step_period(step_period), .pattern_len(pattern_len),
    .rec_set(rec_set), .rec_clr(rec_clr), .clear_all(clear_all),
`ifdef STEP_SEQ_SWING_EN
    .swing(swing),
`endif
    .pos(pos), .step_strobe(step_strobe), .gate(gate), .cur_bits(cur_bits)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      g_until[c] = 0;
      for (int s = 0; s < ST; s++) m_pat[c][s] = 1'b0;
    end
    m_pos = 0; m_el = 0; m_strobe = 1'b0;
  endtask

  function automatic int eff_dur();
    int p, s;
    p = (step_period == 0) ? 1 : int'(step_period);
    s = 0;
`ifdef STEP_SEQ_SWING_EN
    s = (int'(swing) > p - 1) ? p - 1 : int'(swing);
`endif
    return (m_pos % 2 == 0) ? p + s : p - s;
  endfunction

  task automatic model_step();
    int  l, d, np;
    bit  ent;
    bit  old [CH][ST];
    old = m_pat;
    l   = (pattern_len == 0 || pattern_len > ST) ? ST : int'(pattern_len);
    d   = eff_dur();
    ent = 1'b0;
    np  = m_pos;
    if (rewind) begin
      np = 0; m_el = 0; ent = run;
    end else if (run) begin
      if (m_el >= d - 1) begin
        np = (m_pos >= l - 1) ? 0 : m_pos + 1; m_el = 0; ent = 1'b1;
      end else m_el++;
    end
    for (int c = 0; c < CH; c++) begin
      if (clear_all) for (int s = 0; s < ST; s++) m_pat[c][s] = 1'b0;
      else if (rec_clr[c]) m_pat[c][m_pos] = 1'b0;
      else if (rec_set[c]) m_pat[c][m_pos] = 1'b1;
      if (ent && old[c][np]) g_until[c] = m_cyc + G;
    end
    m_pos = np;
    m_strobe = ent;
  endtask

  task automatic check_all();
    logic [CH-1:0] eg, eb;
    for (int c = 0; c < CH; c++) begin
      eg[c] = (m_cyc < g_until[c]);
      eb[c] = m_pat[c][m_pos];
    end
    chk("pos", pos, m_pos);
    chk("step_strobe", step_strobe, m_strobe);
    chk("gate", gate, eg);
    chk("cur_bits", cur_bits, eb);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    m_cyc++;
    if (!reset) model_reset();
    else model_step();
    @(negedge sys_clk);
    check_all();
  endtask

  task automatic wait_pos(input int p, input int budget);
    for (int i = 0; i < budget && pos != p; i++) cycle();
    chk("reach_pos", pos, p);
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin cycle(); n++; end while (!step_strobe && n < budget);
  endtask

  initial begin
    int n, hi;
    model_reset();
    // reset state
    repeat (3) cycle();
    chk("reset_pos", pos, 0);
    chk("reset_gate", gate, 0);
    reset = 1'b1;

    // basic run, record step 0 of channel 0
    run = 1'b1; step_period = 4; rec_set = 4'b0001;
    cycle();
    rec_set = '0;
    n = 0;
    for (int i = 0; i < 64; i++) begin cycle(); if (step_strobe) n++; end
    chk("strobe_count", n, 16);
    for (int i = 0; i < 80 && !(step_strobe && pos == 0); i++) cycle();
    chk("gate0_on_entry", gate[0], 1);
    hi = 1;
    while (gate[0] && hi < 40) begin cycle(); if (gate[0]) hi++; end
    chk("gate0_len", hi, G);

    // shorten length while beyond it
    wait_pos(9, 80);
    pattern_len = 5;
    wait_strobe(10, n);
    chk("short_wrap", pos, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_strobe(10, n);
      chk("short_seq", pos, k % 5);
    end

    // set+clear together, then set on the advance cycle
    for (int i = 0; i < 40 && !(step_strobe && pos == 3); i++) cycle();
    rec_set = 4'b0010; rec_clr = 4'b0010;
    cycle();
    rec_set = '0; rec_clr = '0;
    chk("setclr_bit", cur_bits[1], 0);
    repeat (2) cycle();
    rec_set = 4'b0010;
    cycle();
    rec_set = '0;
    chk("adv_pos", pos, 4);
    chk("adv_bit_not_next", cur_bits[1], 0);
    wait_pos(3, 30);
    chk("adv_bit_prev", cur_bits[1], 1);

    // rewind while stopped
    pattern_len = 0;
    wait_pos(7, 80);
    run = 1'b0; rewind = 1'b1;
    cycle();
    rewind = 1'b0;
    chk("rew_stop_pos", pos, 0);
    chk("rew_stop_strobe", step_strobe, 0);

    // retrigger continuity on channel 2 (steps 0 and 1)
    clear_all = 1'b1; cycle(); clear_all = 1'b0;
    step_period = 1; rec_set = 4'b0100; cycle(); rec_set = '0;
    run = 1'b1; cycle(); run = 1'b0;
    rec_set = 4'b0100; cycle(); rec_set = '0;
    step_period = 6; rewind = 1'b1; cycle();
    run = 1'b1; cycle(); rewind = 1'b0;
    chk("rew_run_strobe", step_strobe, 1);
    chk("rew_run_gate2", gate[2], 1);
    hi = 1;
    while (gate[2] && hi < 40) begin cycle(); if (gate[2]) hi++; end
    chk("gate2_continuous", hi, 16);

    // randomized phase
    for (int i = 0; i < 300; i++) begin
      run         = ($urandom % 8) != 0;
      rewind      = ($urandom % 40) == 0;
      clear_all   = ($urandom % 60) == 0;
      step_period = $urandom_range(0, 5);
      pattern_len = $urandom_range(0, 20);
      rec_set     = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0;
      rec_clr     = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0;
`ifdef STEP_SEQ_SWING_EN
      swing       = $urandom_range(0, 6);
`endif
      cycle();
    end
    rewind = 1'b0; clear_all = 1'b0; rec_set = '0; rec_clr = '0;
    pattern_len = 0; step_period = 3;
`ifdef STEP_SEQ_SWING_EN
    swing = '0;
`endif

    // asynchronous reset mid-gate
    run = 1'b0; rewind = 1'b1; rec_set = 4'b1111; cycle();
    rec_set = '0; run = 1'b1; cycle(); rewind = 1'b0;
    cycle();
    chk("pre_reset_gate", gate, 4'b1111);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) cycle();
    #2 reset = 1'b1;
    repeat (6) cycle();

`ifdef STEP_SEQ_SWING_EN
    step_period = 10; swing = 3; rewind = 1'b1; cycle(); rewind = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(100, n);
      chk("swing3_dur", n, (k % 2 == 0) ? 13 : 7);
    end
    swing = 50; rewind = 1'b1; cycle(); rewind = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(100, n);
      chk("swing50_dur", n, (k % 2 == 0) ? 19 : 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Parametrised multi-channel step sequencer: CHANNELS independent on/off patterns of STEPS steps, held in registers and stepped at a programmable rate derived from sys_clk. It generalises the single-channel, fixed 16-step, fixed-rate recorder to variable length, run/stop/rewind control and per-channel gate pulses. Gates drive envelope/monostable starts of the voice generators ahead of the audio codec; live record/clear keys edit the pattern at the current step.

Parameters:
CHANNELS, 4, number of pattern channels (1..16)
STEPS, 16, pattern depth (power of two, 2..64); POS_W = clog2(STEPS)
PERIOD_W, 32, width of step_period
GATE_CYCLES, 2_500_000, gate high time in sys_clk cycles (>=1)

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous active-low reset
run  in  1  1 = advance steps, 0 = hold position
rewind  in  1  synchronous: return to step 0
step_period  in  PERIOD_W  sys_clk cycles per step
pattern_len  in  POS_W+1  active length; 0 or >STEPS means STEPS
rec_set  in  CHANNELS  set current-step bit per channel
rec_clr  in  CHANNELS  clear current-step bit per channel
clear_all  in  1  clear whole pattern
pos  out  POS_W  current step index
step_strobe  out  1  one-cycle pulse on each step entry
gate  out  CHANNELS  per-channel gate pulses
cur_bits  out  CHANNELS  pattern bits at pos (for LEDs)

Behaviour:
- Reset (reset low, async): pattern all 0, pos=0, tick counter 0, step_strobe=0, gate=0, gate counters 0; cur_bits therefore 0.
- Effective period P = max(step_period,1); effective length L = (pattern_len==0 || pattern_len>STEPS) ? STEPS : pattern_len.
- Tick counter: run=1 counts 0..P-1; at P-1 it returns to 0 and the step advances. run=0 holds the counter value and pos; no strobes. step_period change takes effect next compare; if counter already >= P-1, advance on next cycle.
- Advance: pos <= (pos >= L-1) ? 0 : pos+1 (also recovers from pos beyond a shortened L). step_strobe high in the same cycle pos shows the new value.
- rewind (priority over advance): pos<=0, counter<=0; if run=1, step_strobe and gates issued for step 0 that cycle; if run=0, no strobe.
- Gates: on each step entry, for every channel whose bit at the new pos is 1, gate[c]<=1 and its counter loads GATE_CYCLES-1; counter decrements, gate drops when it hits 0 -> high exactly GATE_CYCLES cycles. Retrigger on a new set step reloads (gate stays high continuously). Channels with bit 0 are not cut off.
- Recording: each cycle, bit[c][pos] <= (bit | rec_set[c]) & ~rec_clr[c] (clear wins). On an advance cycle the write targets the pre-advance pos. Recording does not trigger gates.
- clear_all: all bits 0 that cycle; overrides rec_set; gates already running finish.
- cur_bits = combinational view of pattern at registered pos; reflects a write one cycle after it.
- Reset mid-gate or mid-step: all state cleared immediately, no glitch pulse on release.

Optional Feature:
STEP_SEQ_SWING_EN: adds input swing [PERIOD_W-2:0]. S = min(swing, P-1). Steps with even pos last P+S cycles, odd pos last P-S cycles; average rate unchanged. Without the macro, port absent and every step lasts P cycles.

Test Plan:
- Reset, run=1, step_period=4, len=0, rec_set[0] pulsed at pos 0 -> pos 0..15 wrap to 0, strobe every 4 cycles, gate[0] high GATE_CYCLES on each entry to step 0.
- pattern_len=5 while pos=9 -> next advance pos=0; then 0..4 repeat.
- rec_set[1] and rec_clr[1] asserted together at pos 3 -> bit stays 0; rec_set alone on the advance cycle from 3 -> bit at 3 set, not 4.
- GATE_CYCLES=10, step_period=6, channel 2 set at steps 0 and 1 -> gate[2] continuous 16 cycles from step-0 entry.
- run=0 at pos 7, rewind -> pos=0, no strobe; run=1 with rewind -> strobe same cycle, gates for step 0.
- STEP_SEQ_SWING_EN, step_period=10, swing=3 -> step durations 13,7,13,7; swing=50 -> 19,1.
